// File: rtl/apb_gpo_arbiter.sv
// Two-master APB arbiter in front of the GPO slave (cr/odr pair).
// Round-robin grant, one transfer at a time, timeout aborts with PSLVERR.
module apb_gpo_arbiter #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic [DATA_W-1:0] s_prdata,
    input  logic              s_pready,
    output logic              grant
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t state, state_nx;

    logic              gnt, gnt_nx;
    logic              fav, fav_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic              write_q, write_nx;
    logic [DATA_W-1:0] rdata_q, rdata_nx;
    logic              err_q, err_nx;
    logic [CW-1:0]     cnt_q, cnt_nx;

    logic              req_any;
    logic              pick;
    logic              pick_write;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;
    logic              done0;
    logic              done1;

    // The access-phase strobe carries no extra information here: a master
    // is requesting for as long as its psel is high.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    // fav names the master that wins the next conflict
    always_comb begin
        req_any    = m0_psel | m1_psel;
        pick       = (m0_psel & m1_psel) ? fav : m1_psel;
        pick_write = pick ? m1_pwrite : m0_pwrite;
        pick_addr  = pick ? m1_paddr  : m0_paddr;
        pick_wdata = pick ? m1_pwdata : m0_pwdata;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            fav     <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            fav     <= fav_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
            write_q <= write_nx;
            rdata_q <= rdata_nx;
            err_q   <= err_nx;
            cnt_q   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        fav_nx   = fav;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        write_nx = write_q;
        rdata_nx = rdata_q;
        err_nx   = err_q;
        cnt_nx   = cnt_q;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    gnt_nx   = pick;
                    fav_nx   = ~pick;
                    addr_nx  = pick_addr;
                    wdata_nx = pick_wdata;
                    write_nx = pick_write;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                cnt_nx   = '0;
                state_nx = ACCESS;
            end
            ACCESS: begin
                if (s_pready) begin
                    rdata_nx = write_q ? '0 : s_prdata;
                    err_nx   = 1'b0;
                    state_nx = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_nx = '0;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Downstream fields come straight from the capture registers, so they
    // cannot move between SETUP and the end of ACCESS.
    assign s_psel    = (state == SETUP) || (state == ACCESS);
    assign s_penable = (state == ACCESS);
    assign s_paddr   = addr_q;
    assign s_pwdata  = wdata_q;
    assign s_pwrite  = write_q;
    assign grant     = gnt;

    assign done0 = (state == DONE) && !gnt;
    assign done1 = (state == DONE) &&  gnt;

    assign m0_pready  = done0;
    assign m0_pslverr = done0 & err_q;
    assign m0_prdata  = done0 ? rdata_q : '0;

    assign m1_pready  = done1;
    assign m1_pslverr = done1 & err_q;
    assign m1_prdata  = done1 ? rdata_q : '0;

endmodule

// File: tb/tb_apb_gpo_arbiter.sv
// Bench for apb_gpo_arbiter: two scripted APB masters, a GPO slave model
// and a transaction-level schedule model predicting every cycle.
module tb_apb_gpo_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    logic [1:0]    mpsel, mpen, mpwr, mpready, mpslverr;
    logic [AW-1:0] mpaddr [2];
    logic [DW-1:0] mpwdata[2];
    logic [DW-1:0] mprdata[2];

    logic          s_psel, s_penable, s_pwrite, s_pready;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata, s_prdata;
    logic          grant;

    apb_gpo_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .m0_psel(mpsel[0]), .m0_penable(mpen[0]), .m0_pwrite(mpwr[0]),
        .m0_paddr(mpaddr[0]), .m0_pwdata(mpwdata[0]),
        .m0_prdata(mprdata[0]), .m0_pready(mpready[0]),
        .m0_pslverr(mpslverr[0]),
        .m1_psel(mpsel[1]), .m1_penable(mpen[1]), .m1_pwrite(mpwr[1]),
        .m1_paddr(mpaddr[1]), .m1_pwdata(mpwdata[1]),
        .m1_prdata(mprdata[1]), .m1_pready(mpready[1]),
        .m1_pslverr(mpslverr[1]),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
        .s_pready(s_pready), .grant(grant)
    );

    // GPO slave: registered PREADY, cr at addr 0, odr at addr 4
    logic          stall;
    logic [DW-1:0] slv_cr, slv_odr;
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            s_pready <= 1'b0;
            s_prdata <= '0;
            slv_cr   <= '0;
            slv_odr  <= '0;
        end else if (s_psel && s_penable && !s_pready && !stall) begin
            s_pready <= 1'b1;
            if (s_pwrite) begin
                if (s_paddr[2]) slv_odr <= s_pwdata;
                else            slv_cr  <= s_pwdata;
            end else begin
                s_prdata <= s_paddr[2] ? slv_odr : slv_cr;
            end
        end else begin
            s_pready <= 1'b0;
        end
    end

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            gap;
    } txn_t;

    txn_t mq[2][$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // schedule model: one transfer occupies the slave from the cycle it is
    // picked up until its completion cycle; the next pick is one cycle later
    bit            act;
    int            a_m, a_start, a_done, free_at;
    bit            fav;
    int            last_g;
    bit            a_wr, a_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic [DW-1:0] gpo[2];

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)",
                   tag, obs, exp_v, cyc);
        end
    endtask

    task automatic push(input int m, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap);
        txn_t t;
        t.wr   = wr;
        t.addr = a;
        t.data = d;
        t.gap  = gap;
        mq[m].push_back(t);
    endtask

    task automatic model_eval();
        int m;
        if (!act && cyc >= free_at && mpsel != 2'b00) begin
            if (mpsel == 2'b11) m = fav ? 1 : 0;
            else                m = mpsel[1] ? 1 : 0;
            fav     = (m == 0);
            act     = 1'b1;
            a_m     = m;
            a_start = cyc;
            a_done  = cyc + (stall ? TO + 2 : 4);
            a_wr    = mpwr[m];
            a_addr  = mpaddr[m];
            a_wdata = mpwdata[m];
            if (stall) begin
                a_rdata = '0;
                a_err   = 1'b1;
            end else begin
                a_err = 1'b0;
                if (a_wr) begin
                    gpo[a_addr[2]] = a_wdata;
                    a_rdata = '0;
                end else begin
                    a_rdata = gpo[a_addr[2]];
                end
            end
        end
    endtask

    task automatic check_cycle(output logic [1:0] seen);
        bit exp_pr, in_x, in_a;
        int eg;
        for (int m = 0; m < 2; m++) begin
            exp_pr  = act && cyc == a_done && a_m == m;
            seen[m] = mpready[m];
            chk($sformatf("m%0d_pready", m), mpready[m], exp_pr);
            chk($sformatf("m%0d_prdata", m), mprdata[m],
                exp_pr ? a_rdata : '0);
            chk($sformatf("m%0d_pslverr", m), mpslverr[m],
                exp_pr ? a_err : 1'b0);
        end
        in_x = act && cyc > a_start && cyc < a_done;
        in_a = act && cyc > a_start + 1 && cyc < a_done;
        chk("s_psel", s_psel, in_x);
        chk("s_penable", s_penable, in_a);
        if (in_x) begin
            chk("s_paddr", s_paddr, a_addr);
            chk("s_pwdata", s_pwdata, a_wdata);
            chk("s_pwrite", s_pwrite, a_wr);
        end
        eg = (act && cyc > a_start) ? a_m : last_g;
        chk("grant", grant, eg[0]);
        if (act && cyc == a_done) begin
            act     = 1'b0;
            free_at = cyc + 1;
            last_g  = a_m;
        end
    endtask

    task automatic drive_masters(input logic [1:0] seen);
        txn_t t;
        for (int m = 0; m < 2; m++) begin
            if (mpsel[m] && seen[m]) begin
                mpsel[m] = 1'b0;
                mpen[m]  = 1'b0;
            end else if (mpsel[m]) begin
                mpen[m] = 1'b1;
            end
            if (!mpsel[m] && mq[m].size() > 0) begin
                t = mq[m][0];
                if (t.gap > 0) begin
                    t.gap--;
                    mq[m][0] = t;
                end else begin
                    void'(mq[m].pop_front());
                    mpsel[m]   = 1'b1;
                    mpen[m]    = 1'b0;
                    mpwr[m]    = t.wr;
                    mpaddr[m]  = t.addr;
                    mpwdata[m] = t.data;
                end
            end
        end
    endtask

    task automatic step();
        logic [1:0] seen;
        model_eval();
        @(negedge PCLK);
        check_cycle(seen);
        @(posedge PCLK);
        #1;
        cyc++;
        drive_masters(seen);
    endtask

    task automatic run_all(input int budget);
        int n = 0;
        while ((mq[0].size() > 0 || mq[1].size() > 0 || mpsel != 2'b00
                || act) && n < budget) begin
            step();
            n++;
        end
        chk("run_budget", (n < budget), 1'b1);
        chk("gpo_cr", slv_cr, gpo[0]);
        chk("gpo_odr", slv_odr, gpo[1]);
    endtask

    task automatic model_reset();
        act     = 1'b0;
        free_at = cyc;
        fav     = 1'b0;
        last_g  = 0;
        gpo[0]  = '0;
        gpo[1]  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_psel"}, s_psel, 1'b0);
        chk({tag, "_s_penable"}, s_penable, 1'b0);
        chk({tag, "_s_paddr"}, s_paddr, '0);
        chk({tag, "_s_pwdata"}, s_pwdata, '0);
        chk({tag, "_m0_pready"}, mpready[0], 1'b0);
        chk({tag, "_m1_pready"}, mpready[1], 1'b0);
        chk({tag, "_m0_prdata"}, mprdata[0], '0);
        chk({tag, "_m1_pslverr"}, mpslverr[1], 1'b0);
        chk({tag, "_grant"}, grant, 1'b0);
    endtask

    initial begin
        int guard;
        PRESET = 1'b1;
        stall  = 1'b0;
        mpsel  = '0;
        mpen   = '0;
        mpwr   = '0;
        for (int m = 0; m < 2; m++) begin
            mpaddr[m]  = '0;
            mpwdata[m] = '0;
        end
        #2;
        check_all_zero("reset");
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        model_reset();

        // single write, then odr write and read-back from M1
        push(0, 1'b1, 3'd0, 32'h0000_00FF, 0);
        run_all(50);
        push(0, 1'b1, 3'd4, 32'h0000_00A5, 0);
        run_all(50);
        push(1, 1'b0, 3'd4, 32'h0, 0);
        run_all(50);

        // three rounds of simultaneous requests
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b1, 3'd0, 32'h1000 + i, 0);
            push(1, 1'b0, 3'd0, 32'h2000 + i, 0);
        end
        run_all(200);

        // uncontended back-to-back writes from M0
        for (int i = 0; i < 4; i++)
            push(0, 1'b1, 3'(4 * (i % 2)), 32'hC0DE_0000 + i, 0);
        run_all(100);

        // slave never answers: timeout abort
        stall = 1'b1;
        push(0, 1'b0, 3'd4, 32'h0, 0);
        run_all(100);
        push(1, 1'b1, 3'd0, 32'hDEAD_BEEF, 0);
        run_all(100);
        stall = 1'b0;

        // randomized mixed traffic
        for (int i = 0; i < 40; i++)
            push($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) ? 3'd4 : 3'd0, $urandom,
                 $urandom_range(0, 2));
        run_all(2000);

        // M1 served, then reset lands in M0's ACCESS phase
        push(1, 1'b0, 3'd0, 32'h0, 0);
        run_all(50);
        push(0, 1'b1, 3'd4, 32'h5555_AAAA, 0);
        guard = 0;
        while (!(act && cyc == a_start + 2) && guard < 20) begin
            step();
            guard++;
        end
        chk("reach_access", (guard < 20), 1'b1);
        chk("pre_reset_s_penable", s_penable, 1'b1);
        #2;
        PRESET = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge PCLK);
        check_all_zero("held_reset");
        @(posedge PCLK);
        #1;
        mpsel  = '0;
        mpen   = '0;
        mq[0].delete();
        mq[1].delete();
        PRESET = 1'b0;
        cyc    = cyc + 2;
        model_reset();
        @(negedge PCLK);
        check_all_zero("post_reset");
        @(posedge PCLK);
        #1;
        cyc++;

        // both pending after reset: M0 must win
        push(0, 1'b0, 3'd0, 32'h0, 0);
        push(1, 1'b1, 3'd4, 32'h0000_0042, 0);
        run_all(100);
        push(1, 1'b0, 3'd4, 32'h0, 1);
        run_all(50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
